// File: rtl/ring_osc_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
package ring_osc_pkg;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    REPORT  = 2'd3
  } state_t;

  // Observation bundle so checkers can bind to the FSM without hierarchy.
  typedef struct packed {
    state_t state;
    logic   osc_synced;
  } dbg_t;

  // Defaults: 1 s gate at a 12 MHz board clock, 1024-cycle settle.
  localparam int unsigned DEF_GATE_CYCLES   = 12_000_000;
  localparam int unsigned DEF_SETTLE_CYCLES = 1024;

  // All-ones value of a count_w-bit unsigned counter (count_w <= 32).
  function automatic logic [31:0] count_sat_max(input int unsigned count_w);
    if (count_w >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << count_w) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchroniser for an asynchronous level plus a rising-edge
// detector. No filtering: the only effect is a fixed latency.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic synced,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the async input through the flop chain and remember the last synced value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Ring-oscillator frequency meter: powers the oscillator, lets it settle,
// counts rising edges of its divided output over a fixed clk-timed gate,
// and hands the count to a consumer.
//
// Handshake: meas_valid is raised in REPORT and held, together with a
// stable meas_count/overflow, until a cycle where meas_valid && meas_ready;
// that cycle is the transfer and the FSM returns to IDLE. meas_ready may
// be high before meas_valid, giving a single-cycle valid pulse.
module ring_osc_freq_meter
  import ring_osc_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned COUNT_W       = 24,
  parameter int unsigned GATE_W        = 24,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               osc_div_in,
  output logic               osc_enable,
  output logic               busy,
  output logic [COUNT_W-1:0] meas_count,
  output logic               overflow,
  output logic               meas_valid,
  input  logic               meas_ready,
  output dbg_t               dbg
);

  localparam logic [GATE_W-1:0]  GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0]  SETTLE_LAST = GATE_W'(SETTLE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] SAT_MAX     = COUNT_W'(count_sat_max(COUNT_W));

  state_t             state;
  logic [GATE_W-1:0]  timer;
  logic [COUNT_W-1:0] edge_cnt;
  logic               ovf_acc;
  logic               osc_synced;
  logic               osc_rise;
  logic [COUNT_W-1:0] cnt_next;
  logic               ovf_next;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (osc_div_in),
    .synced (osc_synced),
    .rise   (osc_rise)
  );

  // Saturating edge count including this cycle's edge, so the last gate
  // cycle's edge lands in the captured result.
  always_comb begin
    cnt_next = edge_cnt;
    ovf_next = ovf_acc;
    if (state == MEASURE && osc_rise) begin
      if (edge_cnt == SAT_MAX) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = edge_cnt + COUNT_W'(1);
      end
    end
  end

  // Sequencer: settle, gate, report; owns the oscillator enable and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      edge_cnt   <= '0;
      ovf_acc    <= 1'b0;
      osc_enable <= 1'b0;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      meas_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SETTLE;
            osc_enable <= 1'b1;
            busy       <= 1'b1;
            timer      <= '0;
            edge_cnt   <= '0;
            ovf_acc    <= 1'b0;
            meas_count <= '0;
            overflow   <= 1'b0;
          end
        end
        SETTLE: begin
          if (timer == SETTLE_LAST) begin
            state <= MEASURE;
            timer <= '0;
          end else begin
            timer <= timer + GATE_W'(1);
          end
        end
        MEASURE: begin
          edge_cnt <= cnt_next;
          ovf_acc  <= ovf_next;
          if (timer == GATE_LAST) begin
            state      <= REPORT;
            timer      <= '0;
            osc_enable <= 1'b0;
            meas_valid <= 1'b1;
            meas_count <= cnt_next;
            overflow   <= ovf_next;
          end else begin
            timer <= timer + GATE_W'(1);
          end
        end
        REPORT: begin
          // start is not looked at here, so it cannot be queued.
          if (meas_ready) begin
            state      <= IDLE;
            busy       <= 1'b0;
            meas_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          osc_enable <= 1'b0;
          busy       <= 1'b0;
          meas_valid <= 1'b0;
        end
      endcase
    end
  end

  assign dbg.state      = state;
  assign dbg.osc_synced = osc_synced;

endmodule

// File: doc/ring_osc_freq_meter.md
Name: ring_osc_freq_meter

Overview:
- Measures the frequency of a free-running ring oscillator by counting rising edges of its divided output over a fixed gate window timed by the board clock.
- Owns the oscillator enable: powers the oscillator only for settling and measurement, then returns it to off.
- Presents the result to a downstream consumer, such as a UART reporter or LED display, through a valid/ready handshake.

Parameters:
- GATE_CYCLES, 12000000, length of the measurement window in clk cycles (1 s at 12 MHz).
- SETTLE_CYCLES, 1024, clk cycles the oscillator runs before counting starts.
- COUNT_W, 24, width of the edge counter and of meas_count.
- GATE_W, 24, width of the window timer; must hold max(GATE_CYCLES, SETTLE_CYCLES).
- SYNC_STAGES, 2, flip-flop stages synchronising osc_div_in (minimum 2).

Ports:
- clk  input  1  board clock; the only clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a measurement; sampled in IDLE only.
- osc_div_in  input  1  divided ring-oscillator output; asynchronous to clk.
- osc_enable  output  1  drives the ring oscillator enable.
- busy  output  1  high whenever state is not IDLE.
- meas_count  output  COUNT_W  number of rising edges counted in the last window.
- overflow  output  1  edge counter saturated during the last window.
- meas_valid  output  1  result available.
- meas_ready  input  1  consumer accepts the result.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset state: while rst_n is low at a clk edge:
  - state goes to IDLE; osc_enable=0, busy=0, meas_valid=0, meas_count=0, overflow=0;
  - synchroniser and edge-detect history clear to 0; timer and counter clear to 0.
- Reset mid-operation: aborts any state immediately; no partial result is ever presented.
- FSM states: IDLE, SETTLE, MEASURE, REPORT.
- IDLE:
  - osc_enable=0.
  - start=1 at edge N: state is SETTLE and osc_enable=1 from N+1; timer loads 0; edge counter and overflow clear.
- SETTLE:
  - osc_enable=1; synchroniser runs and edge history is primed; edges are not counted.
  - Lasts exactly SETTLE_CYCLES cycles, then MEASURE; timer reloads 0.
- MEASURE:
  - osc_enable=1; lasts exactly GATE_CYCLES cycles.
  - An edge is counted in a cycle when that cycle is in MEASURE, synced bit=1 and its previous value=0.
  - Counter saturates at 2^COUNT_W-1. An edge detected while saturated sets overflow sticky for the window.
  - On the last MEASURE cycle (including any edge detected in it) the count is captured into meas_count; next state is REPORT.
- REPORT:
  - osc_enable=0; meas_valid=1.
  - meas_count and overflow are held stable while meas_valid=1 and meas_ready=0.
  - Transfer occurs on a cycle with meas_valid=1 and meas_ready=1; the next state is IDLE and meas_valid=0.
  - meas_ready may be high before valid. A transfer then completes in the first REPORT cycle, so valid is high for exactly 1 cycle.
- Latency: start accepted at edge N gives meas_valid=1 from edge N+1+SETTLE_CYCLES+GATE_CYCLES.
- Result registers after transfer: meas_count and overflow keep their last values in IDLE. They clear only on the next accepted start.
- start outside IDLE: ignored, with no queueing; this includes a start in the same cycle as the REPORT transfer.
- Input rate: osc_div_in must toggle no faster than clk/4 (high and low each at least 2 clk periods). Faster inputs alias; no accuracy is guaranteed.
- Synchroniser: metastability hardening only, no filtering. Detected-edge latency is SYNC_STAGES+1 cycles, and this is constant, so the window remains exactly GATE_CYCLES long in the synced domain.
- Arithmetic: the timer compares against GATE_CYCLES-1 and SETTLE_CYCLES-1; there are no off-by-one extensions. All counters are unsigned.

Decomposition:
- Package ring_osc_pkg:
  - state enum (IDLE, SETTLE, MEASURE, REPORT, 2-bit);
  - default GATE_CYCLES and SETTLE_CYCLES constants;
  - a function returning COUNT_W saturation max.
- Sub-module sync_edge_detect: SYNC_STAGES flip-flop chain plus previous-value register.
  - Outputs: synced level and a single-cycle rise pulse.
  - Clears on rst_n.
- The FSM, timer, saturating counter and handshake stay in ring_osc_freq_meter.

Test Plan (GATE_CYCLES=100, SETTLE_CYCLES=8, COUNT_W=8 unless noted):
- Square wave, period 10 clk, start pulse at cycle 0 -> osc_enable high cycles 1..108; meas_valid at cycle 109; meas_count=10; overflow=0.
- Period 4 clk with COUNT_W=4 -> meas_count=15, overflow=1.
- osc_div_in held 0, then held 1 -> meas_count=0 both times, overflow=0.
- meas_ready low for 20 cycles after valid, start pulsed during that time -> meas_valid stays 1, meas_count stable, osc_enable=0, start ignored. Raising ready gives a 1-cycle transfer, then IDLE; busy=0.
- rst_n low for 1 cycle mid-MEASURE -> next cycle: IDLE, osc_enable=0, meas_valid=0, meas_count=0. A new start then gives a full correct measurement (10 at period 10).
- meas_ready tied high, two back-to-back starts -> each result valid for exactly 1 cycle. The second start is accepted only once the FSM is back in IDLE.
